// File: rtl/pry2oht_arb_if.sv
// Valid/ready bundle between WIDTH requesters, the round-robin arbiter and the shared sink.
interface pry2oht_arb_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DW    = 32
);
    logic [WIDTH-1:0]          req_vld;
    logic [WIDTH-1:0]          req_lst;
    logic [WIDTH-1:0][DW-1:0]  req_dat;
    logic [WIDTH-1:0]          req_rdy;
    logic                      res_vld;
    logic                      res_lst;
    logic [DW-1:0]             res_dat;
    logic                      res_rdy;

    modport master (
        output req_vld, req_lst, req_dat, res_rdy,
        input  req_rdy, res_vld, res_lst, res_dat
    );

    modport slave (
        input  req_vld, req_lst, req_dat, res_rdy,
        output req_rdy, res_vld, res_lst, res_dat
    );
endinterface

// File: rtl/pry2oht_arb.sv
// Round-robin packet arbiter onto one valid/ready sink, built on pry2oht_tree.
// Optional packet locking: define PRY2OHT_ARB_LOCK_EN.
module pry2oht_tree #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SPLIT          = 2,
    parameter int unsigned IMPLEMENTATION = 0,
    parameter string       DIRECTION      = "LSB"
) (
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht
);
    localparam int unsigned GROUPS = (SPLIT >= 1 && SPLIT <= WIDTH && (WIDTH % SPLIT) == 0) ? SPLIT : 1;
    localparam int unsigned GW     = WIDTH / GROUPS;

    logic [WIDTH-1:0] ord;
    logic [WIDTH-1:0] sel;
    logic [GW-1:0]    sub;
    logic             done;
    logic             hit;

    // Two-level tree: first non-empty group wins, then first set bit inside it.
    always_comb begin
        ord  = '0;
        sel  = '0;
        sub  = '0;
        done = 1'b0;
        hit  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++)
            ord[i] = (DIRECTION == "MSB") ? pry[WIDTH-1-i] : pry[i];
        for (int unsigned g = 0; g < GROUPS; g++) begin
            sub = ord[g*GW +: GW];
            if (!done && (|sub)) begin
                done = 1'b1;
                if (IMPLEMENTATION == 0) begin
                    sel[g*GW +: GW] = sub & (-sub);
                end else begin
                    hit = 1'b0;
                    for (int unsigned b = 0; b < GW; b++) begin
                        if (sub[b] && !hit) begin
                            sel[g*GW + b] = 1'b1;
                            hit           = 1'b1;
                        end
                    end
                end
            end
        end
        oht = '0;
        for (int unsigned i = 0; i < WIDTH; i++)
            oht[i] = (DIRECTION == "MSB") ? sel[WIDTH-1-i] : sel[i];
    end
endmodule

module pry2oht_arb #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned DW             = 32,
    parameter int unsigned SPLIT          = 2,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    pry2oht_arb_if.slave     bus,
    output logic [WIDTH-1:0] gnt,
    output logic             lck
);
    logic [WIDTH-1:0] ptr;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] gnt_msk;
    logic [WIDTH-1:0] gnt_raw;
    logic [WIDTH-1:0] arb_gnt;
    logic [WIDTH-1:0] ptr_upd;
    logic [DW-1:0]    res_dat;
    logic             res_lst;
    logic             res_vld;
    logic             xfer;

    assign msk = bus.req_vld & ptr;

    pry2oht_tree #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION), .DIRECTION("LSB")
    ) u_tree_msk (
        .pry(msk),
        .oht(gnt_msk)
    );

    pry2oht_tree #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION), .DIRECTION("LSB")
    ) u_tree_raw (
        .pry(bus.req_vld),
        .oht(gnt_raw)
    );

    assign arb_gnt = (|msk) ? gnt_msk : gnt_raw;

    always_comb begin
        res_dat = '0;
        res_lst = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            res_dat = res_dat | (bus.req_dat[i] & {DW{gnt[i]}});
            res_lst = res_lst | (bus.req_lst[i] & gnt[i]);
        end
    end

    assign res_vld     = |(bus.req_vld & gnt);
    assign bus.res_vld = res_vld;
    assign bus.res_lst = res_lst;
    assign bus.res_dat = res_dat;
    assign bus.req_rdy = gnt & {WIDTH{bus.res_rdy}};
    assign xfer        = res_vld & bus.res_rdy;

    // Thermometer of all bits strictly above the one-hot winner; winner at MSB yields zero.
    assign ptr_upd = ~((gnt << 1) - WIDTH'(1));

`ifdef PRY2OHT_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] gnt_reg, gnt_reg_nxt;
    logic [WIDTH-1:0] ptr_nxt;

    assign gnt = (state == LOCK) ? gnt_reg : arb_gnt;
    assign lck = (state == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt_reg <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            gnt_reg <= gnt_reg_nxt;
            ptr     <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_reg_nxt = gnt_reg;
        ptr_nxt     = ptr;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (res_lst) begin
                        ptr_nxt = ptr_upd;
                    end else begin
                        state_nxt   = LOCK;
                        gnt_reg_nxt = gnt;
                    end
                end
            end
            LOCK: begin
                if (xfer && res_lst) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ptr_upd;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    assign gnt = arb_gnt;
    assign lck = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (xfer)
            ptr <= ptr_upd;
    end
`endif
endmodule

// File: tb/tb_pry2oht_arb.sv
// Self-checking bench for pry2oht_arb: directed vector table, packet/reset sequences, random traffic vs. model.
module tb_pry2oht_arb;
`ifdef PRY2OHT_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int W  = 4;
    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] gnt;
    logic         lck;

    pry2oht_arb_if #(.WIDTH(W), .DW(DW)) bus ();

    pry2oht_arb #(.WIDTH(W), .DW(DW), .SPLIT(2), .IMPLEMENTATION(0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .gnt(gnt),
        .lck(lck)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: index of the last requester that finished a packet, and the locked owner (-1 = none).
    int last_win = W - 1;
    int locked   = -1;

    typedef struct packed {
        logic [W-1:0] vld;
        logic         rdy;
        logic [W-1:0] exp_gnt;
        logic [W-1:0] exp_rrdy;
        logic         exp_rvld;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick();
        if (locked >= 0) return locked;
        for (int k = 1; k <= W; k++) begin
            int j;
            j = (last_win + k) % W;
            if (bus.req_vld[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last_win = W - 1;
        locked   = -1;
    endtask

    task automatic drive(input logic [W-1:0] v, input logic [W-1:0] l, input logic r);
        bus.req_vld = v;
        bus.req_lst = l;
        bus.res_rdy = r;
    endtask

    // Called away from the edge: checks all outputs against the model, then advances it across posedge.
    task automatic model_step(input string nm);
        int g;
        logic [W-1:0]  eg, er;
        logic          ev, el, x;
        logic [DW-1:0] ed;
        g  = pick();
        eg = (g >= 0) ? W'(1) << g : '0;
        ev = (g >= 0) ? bus.req_vld[g] : 1'b0;
        el = (g >= 0) ? bus.req_lst[g] : 1'b0;
        ed = (g >= 0) ? bus.req_dat[g] : '0;
        er = bus.res_rdy ? eg : '0;
        chk({nm, "_gnt"}, 64'(gnt), 64'(eg));
        chk({nm, "_res_vld"}, 64'(bus.res_vld), 64'(ev));
        chk({nm, "_res_lst"}, 64'(bus.res_lst), 64'(el));
        chk({nm, "_res_dat"}, 64'(bus.res_dat), 64'(ed));
        chk({nm, "_req_rdy"}, 64'(bus.req_rdy), 64'(er));
        chk({nm, "_lck"}, 64'(lck), 64'(locked >= 0));
        x = ev && bus.res_rdy;
        @(posedge clk);
        if (x) begin
            if (LOCK_EN && !el) begin
                locked = g;
            end else begin
                locked   = -1;
                last_win = g;
            end
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] pk_gnt[4];
        logic         pk_lck[4];
        logic [W-1:0] pk_lst[4];
        logic [W-1:0] rl;

        drive('0, '0, 1'b0);
        for (int i = 0; i < W; i++) bus.req_dat[i] = 32'hD000_0000 | 32'(i);

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{4'b0011, 1'b0, 4'b0001, 4'b0000, 1'b1};
        tbl[12] = '{4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b1};
        tbl[13] = '{4'b0011, 1'b1, 4'b0010, 4'b0010, 1'b1};
        tbl[14] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1};
        tbl[15] = '{4'b1001, 1'b1, 4'b0001, 4'b0001, 1'b1};

        // Reset state with no requests
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_res_vld", 64'(bus.res_vld), 64'h0);
        chk("rst_req_rdy", 64'(bus.req_rdy), 64'h0);
        chk("rst_lck", 64'(lck), 64'h0);
        chk("rst_res_dat", 64'(bus.res_dat), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Directed single-beat table: rotation, idle, stall, wrap
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].vld, 4'b1111, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d_req_rdy", i), 64'(bus.req_rdy), 64'(tbl[i].exp_rrdy));
            chk($sformatf("tbl%0d_res_vld", i), 64'(bus.res_vld), 64'(tbl[i].exp_rvld));
            chk($sformatf("tbl%0d_lck", i), 64'(lck), 64'h0);
            model_step($sformatf("tbl%0d_m", i));
        end

        // Three-beat packet from requester 0 while requester 1 waits
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        pk_lst = '{4'b0010, 4'b0010, 4'b0011, 4'b0011};
        if (LOCK_EN) begin
            pk_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
            pk_lck = '{1'b0, 1'b1, 1'b1, 1'b0};
        end else begin
            pk_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
            pk_lck = '{1'b0, 1'b0, 1'b0, 1'b0};
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'b0011, pk_lst[i], 1'b1);
            @(negedge clk);
            chk($sformatf("pkt%0d_gnt", i), 64'(gnt), 64'(pk_gnt[i]));
            chk($sformatf("pkt%0d_lck", i), 64'(lck), 64'(pk_lck[i]));
            model_step($sformatf("pkt%0d_m", i));
        end

        // Locked owner drops valid mid-packet, then asynchronous reset while locked on requester 2
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(4'b0100, 4'b0000, 1'b1);
        @(negedge clk);
        model_step("lk_start");
        drive(4'b0010, 4'b0000, 1'b1);
        @(negedge clk);
        model_step("lk_drop");
        drive(4'b0110, 4'b0000, 1'b0);
        @(negedge clk);
        if (LOCK_EN) chk("lk_hold_gnt", 64'(gnt), 64'b0100);
        model_step("lk_hold");
        #2 rst = 1'b1;
        #1;
        chk("rst_async_lck", 64'(lck), 64'h0);
        chk("rst_async_gnt", 64'(gnt), 64'b0010);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_gnt", 64'(gnt), 64'b0010);
        model_step("rst_rel");

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rl = '0;
            for (int i = 0; i < W; i++) begin
                rl[i] = ($urandom_range(0, 2) == 0);
                bus.req_dat[i] = $urandom;
            end
            drive(4'($urandom_range(0, 15)), rl, ($urandom_range(0, 3) != 0));
            @(negedge clk);
            model_step($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
